// File: rtl/gobang_pkg.sv
// gobang_pkg: shared constants, result codes, FSM states
// and the scan direction delta table for the gobang engine.
package gobang_pkg;

  localparam int BOARD_N  = 15;
  localparam int CELLS    = BOARD_N * BOARD_N;
  localparam int WIN_LEN  = 5;
  localparam int START_RC = 7;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_BLACK = 2'd1;
  localparam logic [1:0] WIN_WHITE = 2'd2;
  localparam logic [1:0] WIN_DRAW  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLACE,
    ST_SCAN,
    ST_RESOLVE,
    ST_OVER
  } state_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } delta_t;

  // Directions: row, col, diagonal, anti-diagonal.
  function automatic delta_t dir_delta(
    input logic [1:0] dir
  );
    delta_t d;
    d = '{dr: 2'sd0, dc: 2'sd1};
    case (dir)
      2'd0:    d = '{dr: 2'sd0, dc: 2'sd1};
      2'd1:    d = '{dr: 2'sd1, dc: 2'sd0};
      2'd2:    d = '{dr: 2'sd1, dc: 2'sd1};
      default: d = '{dr: 2'sd1, dc: -2'sd1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gobang_line_scan.sv
// gobang_line_scan: walks 4 directions x 2 phases from the origin
// one neighbour per cycle. In: start/abort, board, origin. Out: done, win.
module gobang_line_scan
  import gobang_pkg::*;
#(
  parameter int SIDE    = BOARD_N,
  parameter int RUN_LEN = WIN_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SIDE*SIDE-1:0]   board,
  input  logic [3:0]             org_row,
  input  logic [3:0]             org_col,
  output logic                   done,
  output logic                   win
);

  localparam int NC = SIDE * SIDE;
  localparam int IW = $clog2(NC);
  localparam logic signed [4:0] LAST = 5'(SIDE - 1);
  localparam logic [2:0] STEP_MAX = 3'(RUN_LEN - 1);
  localparam logic [2:0] WIN_CNT  = 3'(RUN_LEN);

  logic              active_q, active_d;
  logic [1:0]        dir_q, dir_d;
  logic              bwd_q, bwd_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        cnt_q, cnt_d;
  logic signed [4:0] cur_r_q, cur_r_d;
  logic signed [4:0] cur_c_q, cur_c_d;

  delta_t            dlt;
  logic signed [4:0] dr5, dc5;
  logic signed [4:0] nr, nc;
  logic signed [4:0] org_r5, org_c5;
  logic              oob, hit, phase_end;
  logic [IW-1:0]     idx;
  logic [2:0]        cnt_inc, step_inc;

  assign org_r5 = {1'b0, org_row};
  assign org_c5 = {1'b0, org_col};

  always_comb begin
    dlt = dir_delta(dir_q);
    dr5 = {{3{dlt.dr[1]}}, dlt.dr};
    dc5 = {{3{dlt.dc[1]}}, dlt.dc};
    if (bwd_q) begin
      dr5 = -dr5;
      dc5 = -dc5;
    end
    // Coordinates stay in 0..14, so a step lands in -1..15.
    nr  = cur_r_q + dr5;
    nc  = cur_c_q + dc5;
    oob = nr[4] || nc[4] || (nr > LAST) || (nc > LAST);
    idx = IW'(nr[3:0]) * IW'(SIDE) + IW'(nc[3:0]);
    hit = !oob && board[idx];
    cnt_inc  = cnt_q + 3'd1;
    step_inc = step_q + 3'd1;
  end

  always_comb begin
    active_d  = active_q;
    dir_d     = dir_q;
    bwd_d     = bwd_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    cur_r_d   = cur_r_q;
    cur_c_d   = cur_c_q;
    phase_end = 1'b0;
    done      = 1'b0;
    win       = 1'b0;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      dir_d    = 2'd0;
      bwd_d    = 1'b0;
      step_d   = 3'd0;
      cnt_d    = 3'd1;
      cur_r_d  = org_r5;
      cur_c_d  = org_c5;
    end else if (active_q) begin
      if (hit) begin
        if (cnt_inc == WIN_CNT) begin
          done     = 1'b1;
          win      = 1'b1;
          active_d = 1'b0;
        end else begin
          cnt_d   = cnt_inc;
          step_d  = step_inc;
          cur_r_d = nr;
          cur_c_d = nc;
          phase_end = (step_inc == STEP_MAX);
        end
      end else begin
        phase_end = 1'b1;
      end
      if (phase_end) begin
        cur_r_d = org_r5;
        cur_c_d = org_c5;
        step_d  = 3'd0;
        if (!bwd_q) begin
          // Backward phase keeps the forward count.
          bwd_d = 1'b1;
        end else if (dir_q == 2'd3) begin
          done     = 1'b1;
          active_d = 1'b0;
        end else begin
          dir_d = dir_q + 2'd1;
          bwd_d = 1'b0;
          cnt_d = 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      dir_q    <= 2'd0;
      bwd_q    <= 1'b0;
      step_q   <= 3'd0;
      cnt_q    <= 3'd1;
      cur_r_q  <= '0;
      cur_c_q  <= '0;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      bwd_q    <= bwd_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      cur_r_q  <= cur_r_d;
      cur_c_q  <= cur_c_d;
    end
  end

endmodule

// File: rtl/gobang_game_ctrl.sv
// gobang_game_ctrl: key pulses -> cursor, stones, turns, win scan.
// Out: registered board vectors, cursor, who_win, turn, busy.
module gobang_game_ctrl
  import gobang_pkg::*;
#(
  parameter int BOARD_N  = 15,
  parameter int WIN_LEN  = 5,
  parameter int START_RC = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_up,
  input  logic                         key_down,
  input  logic                         key_left,
  input  logic                         key_right,
  input  logic                         key_place,
  input  logic                         new_game,
  output logic [BOARD_N*BOARD_N-1:0]   display_black,
  output logic [BOARD_N*BOARD_N-1:0]   display_white,
  output logic [3:0]                   choose_row,
  output logic [3:0]                   choose_col,
  output logic [1:0]                   who_win,
  output logic                         turn,
  output logic                         busy
);

  localparam int NC = BOARD_N * BOARD_N;
  localparam int IW = $clog2(NC);
  localparam logic [3:0] LAST = 4'(BOARD_N - 1);
  localparam logic [3:0] HOME = 4'(START_RC);
  localparam logic [7:0] FULL = 8'(NC);

  state_t          state_q, state_d;
  logic [NC-1:0]   black_q, black_d;
  logic [NC-1:0]   white_q, white_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      org_row_q, org_row_d;
  logic [3:0]      org_col_q, org_col_d;
  logic [1:0]      who_win_q, who_win_d;
  logic            turn_q, turn_d;
  logic            busy_q, busy_d;
  logic            win_q, win_d;
  logic [7:0]      stones_q, stones_d;

  logic [IW-1:0]   cur_idx, org_idx;
  logic            occupied;
  logic            scan_start;
  logic            scan_done, scan_win;
  logic [NC-1:0]   scan_board;

  assign cur_idx  = IW'(row_q) * IW'(BOARD_N) + IW'(col_q);
  assign org_idx  = IW'(org_row_q) * IW'(BOARD_N) + IW'(org_col_q);
  assign occupied = black_q[cur_idx] | white_q[cur_idx];
  assign scan_board = turn_q ? white_q : black_q;

  gobang_line_scan #(
    .SIDE    (BOARD_N),
    .RUN_LEN (WIN_LEN)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (scan_start),
    .abort   (new_game),
    .board   (scan_board),
    .org_row (org_row_q),
    .org_col (org_col_q),
    .done    (scan_done),
    .win     (scan_win)
  );

  always_comb begin
    state_d    = state_q;
    black_d    = black_q;
    white_d    = white_q;
    row_d      = row_q;
    col_d      = col_q;
    org_row_d  = org_row_q;
    org_col_d  = org_col_q;
    who_win_d  = who_win_q;
    turn_d     = turn_q;
    win_d      = win_q;
    stones_d   = stones_q;
    scan_start = 1'b0;
    if (new_game) begin
      state_d   = ST_IDLE;
      black_d   = '0;
      white_d   = '0;
      row_d     = HOME;
      col_d     = HOME;
      who_win_d = WIN_NONE;
      turn_d    = 1'b0;
      win_d     = 1'b0;
      stones_d  = 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_place && !occupied) begin
            state_d   = ST_PLACE;
            org_row_d = row_q;
            org_col_d = col_q;
          end else begin
            // Opposing pulses cancel; edges saturate.
            if (key_up && !key_down && row_q != 4'd0)
              row_d = row_q - 4'd1;
            else if (key_down && !key_up && row_q != LAST)
              row_d = row_q + 4'd1;
            if (key_left && !key_right && col_q != 4'd0)
              col_d = col_q - 4'd1;
            else if (key_right && !key_left && col_q != LAST)
              col_d = col_q + 4'd1;
          end
        end
        ST_PLACE: begin
          if (turn_q) white_d[org_idx] = 1'b1;
          else        black_d[org_idx] = 1'b1;
          stones_d   = stones_q + 8'd1;
          scan_start = 1'b1;
          state_d    = ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_done) begin
            win_d   = scan_win;
            state_d = ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (win_q) begin
            who_win_d = turn_q ? WIN_WHITE : WIN_BLACK;
            state_d   = ST_OVER;
          end else if (stones_q == FULL) begin
            who_win_d = WIN_DRAW;
            state_d   = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_IDLE;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_PLACE) ||
             (state_d == ST_SCAN) ||
             (state_d == ST_RESOLVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      black_q   <= '0;
      white_q   <= '0;
      row_q     <= HOME;
      col_q     <= HOME;
      org_row_q <= HOME;
      org_col_q <= HOME;
      who_win_q <= WIN_NONE;
      turn_q    <= 1'b0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      stones_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      black_q   <= black_d;
      white_q   <= white_d;
      row_q     <= row_d;
      col_q     <= col_d;
      org_row_q <= org_row_d;
      org_col_q <= org_col_d;
      who_win_q <= who_win_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
      win_q     <= win_d;
      stones_q  <= stones_d;
    end
  end

  assign display_black = black_q;
  assign display_white = white_q;
  assign choose_row    = row_q;
  assign choose_col    = col_q;
  assign who_win       = who_win_q;
  assign turn          = turn_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_gobang_game_ctrl.sv
// tb_gobang_game_ctrl: directed stimulus; expected placement results
// queued per move and checked by a monitor when busy falls.
module tb_gobang_game_ctrl;
  import gobang_pkg::*;

  localparam int NC = 225;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_up = 1'b0, key_down = 1'b0;
  logic key_left = 1'b0, key_right = 1'b0;
  logic key_place = 1'b0, new_game = 1'b0;
  logic [NC-1:0] display_black, display_white;
  logic [3:0] choose_row, choose_col;
  logic [1:0] who_win;
  logic turn, busy;

  always #20 clk = ~clk;

  gobang_game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_place     (key_place),
    .new_game      (new_game),
    .display_black (display_black),
    .display_white (display_white),
    .choose_row    (choose_row),
    .choose_col    (choose_col),
    .who_win       (who_win),
    .turn          (turn),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0]    ww;
    logic          trn;
    int            idx;
    logic          white;
    logic          bitv;
    logic [NC-1:0] b;
    logic [NC-1:0] w;
    int            dur;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  logic [NC-1:0] mb, mw;
  int mr, mc;
  logic mturn;

  task automatic chk(input string nm,
                     input logic [NC-1:0] act,
                     input logic [NC-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: busy falling marks a resolved placement.
  initial begin
    exp_t e;
    int dur;
    logic bprev;
    logic act;
    dur = 0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        dur++;
      end else if (bprev === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_busy_fall", NC'(dur), '0);
        end else begin
          e = sbq.pop_front();
          act = e.white ? display_white[e.idx]
                        : display_black[e.idx];
          chk("who_win", NC'(who_win), NC'(e.ww));
          chk("turn", NC'(turn), NC'(e.trn));
          chk("stone_bit", NC'(act), NC'(e.bitv));
          chk("black_vec", display_black, e.b);
          chk("white_vec", display_white, e.w);
          if (e.dur > 0)
            chk("busy_cycles", NC'(dur), NC'(e.dur));
        end
        dur = 0;
      end
      bprev = busy;
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic drive(input logic u, d, l, r, p, g);
    key_up = u; key_down = d;
    key_left = l; key_right = r;
    key_place = p; new_game = g;
    @(negedge clk);
    key_up = 0; key_down = 0;
    key_left = 0; key_right = 0;
    key_place = 0; new_game = 0;
  endtask

  task automatic mv(input logic u, d, l, r);
    drive(u, d, l, r, 1'b0, 1'b0);
    if (u && !d && mr > 0) mr--;
    else if (d && !u && mr < 14) mr++;
    if (l && !r && mc > 0) mc--;
    else if (r && !l && mc < 14) mc++;
  endtask

  task automatic go(input int r, input int c);
    int n = 0;
    while ((mr != r || mc != c) && n < 40) begin
      mv(r < mr, r > mr, c < mc, c > mc);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0)
      chk("busy_timeout", NC'(busy), '0);
  endtask

  task automatic ng();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mb = '0; mw = '0;
    mr = 7; mc = 7;
    mturn = 1'b0;
  endtask

  task automatic place(input int r, input int c,
                       input logic [1:0] ww, input int dur);
    exp_t e;
    go(r, c);
    e.idx = r * 15 + c;
    e.white = mturn;
    e.bitv = 1'b1;
    if (mturn) mw[e.idx] = 1'b1;
    else       mb[e.idx] = 1'b1;
    if (ww == WIN_NONE) mturn = ~mturn;
    e.ww = ww;
    e.trn = mturn;
    e.b = mb;
    e.w = mw;
    e.dur = dur;
    sbq.push_back(e);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();
  endtask

  initial begin
    exp_t e;
    logic rose;
    int blist[$], wlist[$];

    #5 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_black", display_black, '0);
    chk("rst_white", display_white, '0);
    chk("rst_row", NC'(choose_row), NC'(7));
    chk("rst_col", NC'(choose_col), NC'(7));
    chk("rst_who_win", NC'(who_win), '0);
    chk("rst_turn", NC'(turn), '0);
    chk("rst_busy", NC'(busy), '0);
    rst = 1'b1;
    @(negedge clk);
    mb = '0; mw = '0; mr = 7; mc = 7; mturn = 1'b0;

    // Cursor moves.
    mv(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lr_cancel_col", NC'(choose_col), NC'(7));
    mv(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ud_cancel_row", NC'(choose_row), NC'(7));
    mv(1'b1, 1'b0, 1'b0, 1'b1);
    chk("diag_row", NC'(choose_row), NC'(6));
    chk("diag_col", NC'(choose_col), NC'(8));
    mv(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) mv(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) mv(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_row", NC'(choose_row), NC'(10));
    chk("sat_col", NC'(choose_col), NC'(14));
    chk("move_no_stone", display_black, '0);
    chk("move_turn", NC'(turn), '0);

    // Lone stone, then a repeat on the same cell.
    place(7, 7, WIN_NONE, 10);
    chk("bit112", NC'(display_black[112]), NC'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rose = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0) rose = 1'b1;
    end
    chk("dup_busy", NC'(rose), '0);
    chk("dup_turn", NC'(turn), NC'(1));
    chk("dup_white", display_white, '0);

    // Black row win at the top edge.
    ng();
    go(0, 0);
    mv(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat0_row", NC'(choose_row), '0);
    chk("sat0_col", NC'(choose_col), '0);
    place(0, 0, WIN_NONE, 10);
    place(5, 5, WIN_NONE, 0);
    place(0, 1, WIN_NONE, 0);
    place(5, 7, WIN_NONE, 0);
    place(0, 2, WIN_NONE, 0);
    place(9, 9, WIN_NONE, 0);
    place(0, 3, WIN_NONE, 0);
    place(10, 10, WIN_NONE, 0);
    place(0, 4, WIN_BLACK, 7);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    chk("over_row", NC'(choose_row), '0);
    chk("over_col", NC'(choose_col), NC'(4));
    chk("over_who_win", NC'(who_win), NC'(1));
    chk("over_black", display_black, mb);
    chk("over_white", display_white, mw);
    chk("over_busy", NC'(busy), '0);
    ng();
    chk("ng_black", display_black, '0);
    chk("ng_white", display_white, '0);
    chk("ng_row", NC'(choose_row), NC'(7));
    chk("ng_col", NC'(choose_col), NC'(7));
    chk("ng_who_win", NC'(who_win), '0);
    chk("ng_turn", NC'(turn), '0);

    // Anti-diagonal white win, completed from either end.
    for (int v = 0; v < 2; v++) begin
      ng();
      place(14, 0, WIN_NONE, 0);
      place(4, 10, WIN_NONE, 0);
      place(14, 2, WIN_NONE, 0);
      place(5, 9, WIN_NONE, 0);
      place(14, 4, WIN_NONE, 0);
      place(6, 8, WIN_NONE, 0);
      place(14, 6, WIN_NONE, 0);
      place(7, 7, WIN_NONE, 0);
      place(14, 8, WIN_NONE, 0);
      if (v == 0) place(8, 6, WIN_WHITE, 13);
      else        place(3, 11, WIN_WHITE, 12);
      chk("anti_who_win", NC'(who_win), NC'(2));
    end

    // new_game during the third scan cycle.
    ng();
    e.idx = 112; e.white = 1'b0; e.bitv = 1'b0;
    e.ww = WIN_NONE; e.trn = 1'b0;
    e.b = '0; e.w = '0; e.dur = 4;
    sbq.push_back(e);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    ng();
    chk("abort_busy", NC'(busy), '0);
    chk("abort_black", display_black, '0);
    chk("abort_turn", NC'(turn), '0);
    mv(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_idle_col", NC'(choose_col), NC'(8));

    // Full board, no five anywhere: max run is two.
    ng();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        if (((c + 2 * r) % 4) < 2) blist.push_back(r * 15 + c);
        else                        wlist.push_back(r * 15 + c);
    for (int i = 0; i < 113; i++) begin
      place(blist[i] / 15, blist[i] % 15,
            (i == 112) ? WIN_DRAW : WIN_NONE, 0);
      if (i < 112)
        place(wlist[i] / 15, wlist[i] % 15, WIN_NONE, 0);
    end
    chk("draw_who_win", NC'(who_win), NC'(3));
    chk("draw_turn", NC'(turn), '0);
    chk("draw_black", display_black, mb);
    chk("draw_white", display_white, mw);

    repeat (4) @(negedge clk);
    chk("sb_empty", NC'(sbq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
